// File: rtl/sprite_anim_src.sv
// sprite_anim_src: animated sprite pixel source with a palette and an
// optional horizontal mirror.
//
// For each pixel position (x, y) the block works out whether it falls inside
// an H_SIZE x V_SIZE sprite anchored at (x0, y0). It reads a palette code from
// the sprite RAM for the current animation frame and outputs the palette
// color. Outside the sprite, or for palette code 0, it outputs KEY_COLOR.
// sprite_rgb follows x/y with a fixed two-cycle latency.
//
// A kick pulse arms the animation. The next frame_tick starts it. Each frame
// is then held for HOLD_TICKS frame_ticks until the last frame has shown.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   x, y               current pixel position
//   x0, y0             sprite origin
//   frame_tick         one-cycle pulse per video frame
//   kick               one-cycle pulse requesting the animation sequence
//   flip               horizontal mirror request (used only with SPRITE_FLIP_EN)
//   we/addr_w/pixel_in sprite RAM write port (palette codes)
//   plt_we/plt_addr/plt_din  palette write port
//   sprite_rgb         pixel color, KEY_COLOR when transparent
//   busy               high while the animation plays
//
// Build option: define SPRITE_FLIP_EN to build the mirror register.

module sprite_anim_src #(
  parameter int CD         = 12,
  parameter int H_SIZE     = 32,
  parameter int V_SIZE     = 32,
  parameter int FRAMES     = 4,
  parameter int PLT_W      = 3,
  parameter int HOLD_TICKS = 4,
  parameter logic [CD-1:0] KEY_COLOR = 12'h000
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [10:0]                                   x,
  input  logic [10:0]                                   y,
  input  logic [10:0]                                   x0,
  input  logic [10:0]                                   y0,
  input  logic                                          frame_tick,
  input  logic                                          kick,
  input  logic                                          flip,
  input  logic                                          we,
  input  logic [$clog2(FRAMES*H_SIZE*V_SIZE)-1:0]       addr_w,
  input  logic [PLT_W-1:0]                              pixel_in,
  input  logic                                          plt_we,
  input  logic [PLT_W-1:0]                              plt_addr,
  input  logic [CD-1:0]                                 plt_din,
  output logic [CD-1:0]                                 sprite_rgb,
  output logic                                          busy
);

  localparam int HB    = $clog2(H_SIZE);
  localparam int VB    = $clog2(V_SIZE);
  localparam int FB    = $clog2(FRAMES);
  localparam int DEPTH = FRAMES * H_SIZE * V_SIZE;
  localparam int TW    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state_q, state_d;
  logic [FB-1:0]     cur_frame_q, cur_frame_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              pend_q, pend_d;
  logic              busy_q, busy_d;
  logic              rd_vld_q, rd_vld_d;
  logic [CD-1:0]     rgb_q, rgb_d;
  logic [CD-1:0]     palette_q [2**PLT_W];
  logic [CD-1:0]     palette_d [2**PLT_W];
  logic [PLT_W-1:0]  rd_code_q;
  logic [PLT_W-1:0]  ram_mem [DEPTH];

  logic [11:0]       xr, yr;
  logic              in_region;
  logic [HB-1:0]     xc;
  logic [FB+VB+HB-1:0] rd_addr;

  // The 12-bit difference of two zero-extended 11-bit values cannot overflow.
  // A negative offset therefore shows up as bit 11 set. A pixel is inside
  // the sprite exactly when every bit above the in-sprite index is zero.
  assign xr = {1'b0, x} - {1'b0, x0};
  assign yr = {1'b0, y} - {1'b0, y0};
  assign in_region = (xr[11:HB] == '0) && (yr[11:VB] == '0);

`ifdef SPRITE_FLIP_EN
  logic flip_q, flip_d;

  // For 0 <= xr < H_SIZE, H_SIZE-1-xr is the bitwise inverse of the index.
  assign xc = flip_q ? ~xr[HB-1:0] : xr[HB-1:0];
  assign flip_d = frame_tick ? flip : flip_q;

  always_ff @(posedge clk) begin
    if (reset) flip_q <= 1'b0;
    else       flip_q <= flip_d;
  end
`else
  logic unused_flip;

  assign unused_flip = flip;
  assign xc = xr[HB-1:0];
`endif

  assign rd_addr = {cur_frame_q, yr[VB-1:0], xc};

  // Sprite RAM is not reset. A read of the address being written in the same
  // cycle returns the old contents.
  always_ff @(posedge clk) begin
    if (we) ram_mem[addr_w] <= pixel_in;
    rd_code_q <= ram_mem[rd_addr];
  end

  // Second pipeline stage: map the code through the palette. Code 0 is always
  // transparent, whatever palette entry 0 holds.
  always_comb begin
    rd_vld_d = in_region;
    rgb_d    = KEY_COLOR;
    if (rd_vld_q && (rd_code_q != '0)) rgb_d = palette_q[rd_code_q];
    palette_d = palette_q;
    if (plt_we) palette_d[plt_addr] = plt_din;
  end

  // Animation sequencer. Frame and hold counter change only on an accepted
  // frame_tick, so the frame index is stable within a video frame.
  always_comb begin
    state_d     = state_q;
    cur_frame_d = cur_frame_q;
    tick_cnt_d  = tick_cnt_q;
    pend_d      = pend_q;
    case (state_q)
      IDLE: begin
        cur_frame_d = '0;
        if (frame_tick && (pend_q || kick)) begin
          state_d     = PLAY;
          cur_frame_d = FB'(1);
          tick_cnt_d  = '0;
          pend_d      = 1'b0;
        end else if (kick) begin
          pend_d = 1'b1;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (tick_cnt_q == TW'(HOLD_TICKS - 1)) begin
            tick_cnt_d = '0;
            if (cur_frame_q == FB'(FRAMES - 1)) begin
              state_d     = IDLE;
              cur_frame_d = '0;
            end else begin
              cur_frame_d = cur_frame_q + FB'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_frame_q <= '0;
      tick_cnt_q  <= '0;
      pend_q      <= 1'b0;
      busy_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      rgb_q       <= KEY_COLOR;
      palette_q   <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cur_frame_q <= cur_frame_d;
      tick_cnt_q  <= tick_cnt_d;
      pend_q      <= pend_d;
      busy_q      <= busy_d;
      rd_vld_q    <= rd_vld_d;
      rgb_q       <= rgb_d;
      palette_q   <= palette_d;
    end
  end

  assign sprite_rgb = rgb_q;
  assign busy       = busy_q;

endmodule

// File: doc/sprite_anim_src.md
SPRITE_ANIM_SRC -- requirements
Module: sprite_anim_src

Interface
REQ-001 Parameter CD, 12: color depth in bits of the RGB output and of palette entries.
REQ-002 Parameter H_SIZE, 32: sprite width in pixels; power of 2.
REQ-003 Parameter V_SIZE, 32: sprite height in pixels; power of 2.
REQ-004 Parameter FRAMES, 4: number of animation frames stored; power of 2, at least 2.
REQ-005 Parameter PLT_W, 3: palette code width; palette holds 2^PLT_W entries.
REQ-006 Parameter HOLD_TICKS, 4: frame_tick pulses per animation step; at least 1.
REQ-007 Parameter KEY_COLOR, 12'h000: transparent color.
REQ-008 Port clk, input, 1: single system clock.
REQ-009 Port reset, input, 1: synchronous, active-high reset.
REQ-010 Ports x and y, input, 11 each: current pixel position.
REQ-011 Ports x0 and y0, input, 11 each: sprite origin.
REQ-012 Port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-013 Port kick, input, 1: one-cycle pulse that requests the animation sequence.
REQ-014 Port flip, input, 1: horizontal mirror request.
REQ-015 Ports we, addr_w and pixel_in, input, 1 / log2(FRAMES*H_SIZE*V_SIZE) / PLT_W: sprite RAM write port.
REQ-016 Ports plt_we, plt_addr and plt_din, input, 1 / PLT_W / CD: palette write port.
REQ-017 Port sprite_rgb, output, CD: pixel color, or KEY_COLOR when the pixel is transparent.
REQ-018 Port busy, output, 1: high while the animation plays.

Function
REQ-019 Coordinate math:
- xr = x - x0 and yr = y - y0, computed signed and 12 bits wide.
- in_region when 0 <= xr < H_SIZE and 0 <= yr < V_SIZE.
- Coordinates wrapping below 0 or at the 2047 edge SHALL be treated as out of region.
REQ-020 Read address SHALL be {cur_frame, yr[log2 V-1:0], xc[log2 H-1:0]}, where xc = xr unless mirrored (REQ-032).
REQ-021 Sprite RAM: synchronous read with 1-cycle latency; the write and read ports are independent.
- A write and a read to the same address in the same cycle SHALL return the old data.
REQ-022 Palette: 2^PLT_W x CD register file.
- Written on plt_we.
- Code 0 SHALL always output KEY_COLOR, regardless of entry 0's contents.
REQ-023 Output pipeline: sprite_rgb SHALL reflect the x/y presented exactly 2 cycles earlier (RAM read, then output register).
- in_region SHALL be delayed to stay aligned with the RAM data.
- Out-of-region pixels SHALL output KEY_COLOR.
REQ-024 FSM states: IDLE and PLAY.
- cur_frame, tick_cnt and the registered flip SHALL change only in the cycle a frame_tick is accepted, so no frame tears.
REQ-025 IDLE: cur_frame = 0 and busy = 0.
- A kick pulse latches a pending flag.
- On the next frame_tick with the flag set: go to PLAY, set cur_frame = 1, set tick_cnt = 0, clear the flag.
REQ-026 PLAY: each frame_tick increments tick_cnt.
- When tick_cnt = HOLD_TICKS-1 on a frame_tick, clear tick_cnt and advance cur_frame.
- When cur_frame = FRAMES-1 at that point, return to IDLE with cur_frame = 0.
REQ-027 A kick during PLAY SHALL be ignored and SHALL NOT set the pending flag.
- kick and frame_tick in the same IDLE cycle SHALL start PLAY on that tick.
REQ-028 busy = 1 exactly while in PLAY.

Reset
REQ-029 On reset:
- sprite_rgb = KEY_COLOR and the pipeline valid flags clear.
- FSM = IDLE, cur_frame = 0, tick_cnt = 0, pending flag = 0, busy = 0, registered flip = 0.
- All palette entries = 0.
REQ-030 Sprite RAM contents SHALL NOT be reset.
REQ-031 Reset asserted mid-PLAY SHALL return the FSM to IDLE on the next clock edge, with no stray frame advance.

Configuration
REQ-032 Macro SPRITE_FLIP_EN, defined:
- flip is registered on each frame_tick.
- When the registered flip = 1, xc = H_SIZE-1-xr.
REQ-033 Macro SPRITE_FLIP_EN, undefined:
- The flip port still exists but is ignored, and xc = xr.
- No flip register is built.

Verification
REQ-034 Reset, then x=x0=100, y=y0=50, RAM[0] = code 2, palette[2] = 12'hFFF -> sprite_rgb = 12'hFFF exactly 2 cycles after x/y are applied; 12'h000 before that.
REQ-035 x = x0 + 32, or x < x0 with a wrapping difference -> sprite_rgb = KEY_COLOR; palette entry 0 written to 12'hABC, code 0 at an in-region pixel -> KEY_COLOR.
REQ-036 HOLD_TICKS=4, FRAMES=4, kick then 13 frame_ticks:
- cur_frame sequence 1,1,1,1,2,2,2,2,3,3,3,3,0.
- busy falls on the 13th tick.
- A second kick at tick 5 is ignored.
REQ-037 Reset asserted during PLAY at cur_frame = 2 -> next cycle busy = 0, cur_frame = 0, sprite_rgb = KEY_COLOR, palette cleared.
REQ-038 With SPRITE_FLIP_EN: flip = 1 then frame_tick; RAM at xr=0 = code 3, xr=31 = code 5 -> pixel at xr=0 shows palette[5].
- Without the macro -> pixel at xr=0 shows palette[3].
